// File: rtl/execute_mdu.sv
// execute_mdu: iterative RV64/RV32 M-extension multiply/divide unit retiring RADIX_BITS bits per cycle.
// Optional macro MDU_FASTPATH_EN: divide-by-zero, signed overflow and zero-operand multiplies skip RUN.
module execute_mdu #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned RADIX_BITS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam int unsigned PW     = 2 * XLEN;
  localparam int unsigned CW     = 7;
  localparam int unsigned WSHIFT = XLEN - 32;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state;
  logic [2:0]      op_q;
  logic            word_q;
  logic            neg_q;
  logic            div0_q;
  logic            ovf_q;
  logic [XLEN-1:0] a_orig_q;
  logic [PW-1:0]   prod_q;
  logic [PW-1:0]   mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] dvsr_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   last_q;

  function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
    ext32 = sgn ? XLEN'($signed(v)) : XLEN'(v);
  endfunction

  // Applies the sign fixup, selects the product half or quotient/remainder, and handles
  // the divide-by-zero and signed-overflow results.
  function automatic logic [XLEN-1:0] fix_result(
    input logic [2:0]      op,
    input logic            word,
    input logic            neg,
    input logic            div0,
    input logic            ovf,
    input logic [PW-1:0]   prod,
    input logic [XLEN-1:0] quo,
    input logic [XLEN-1:0] rem,
    input logic [XLEN-1:0] a_orig
  );
    logic [PW-1:0]   p;
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] m;
    logic [XLEN-1:0] r;
    p = neg ? PW'(0) - prod : prod;
    q = neg ? XLEN'(0) - quo : quo;
    m = neg ? XLEN'(0) - rem : rem;
    if (!op[2]) begin
      if (op == OP_MUL) r = word ? XLEN'(p[31:0]) : p[XLEN-1:0];
      else              r = word ? XLEN'(p[63:32]) : p[PW-1:XLEN];
    end else if (div0) begin
      r = op[1] ? a_orig : '1;
    end else if (ovf) begin
      r = op[1] ? '0 : a_orig;
    end else begin
      r = op[1] ? m : q;
    end
    if (word) r = XLEN'($signed(r[31:0]));
    return r;
  endfunction

  // Operand preparation for the accept cycle.
  logic            word_eff;
  logic            a_sgn;
  logic            b_sgn;
  logic            a_neg;
  logic            b_neg;
  logic            is_div;
  logic            div0;
  logic            ovf;
  logic            res_neg;
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] a_orig;
  logic [XLEN-1:0] min_val;
  logic [CW-1:0]   last_step;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (in_op)
      OP_MULH, OP_DIV, OP_REM: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      OP_MULHSU: a_sgn = 1'b1;
      default: ;
    endcase
    word_eff  = (XLEN == 64) && in_word;
    a_ext     = word_eff ? ext32(in_a[31:0], a_sgn) : in_a;
    b_ext     = word_eff ? ext32(in_b[31:0], b_sgn) : in_b;
    a_orig    = word_eff ? ext32(in_a[31:0], 1'b1) : in_a;
    min_val   = word_eff ? ext32(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
    a_neg     = a_sgn & a_ext[XLEN-1];
    b_neg     = b_sgn & b_ext[XLEN-1];
    a_mag     = a_neg ? XLEN'(0) - a_ext : a_ext;
    b_mag     = b_neg ? XLEN'(0) - b_ext : b_ext;
    is_div    = in_op[2];
    div0      = is_div && (b_ext == '0);
    ovf       = is_div && !in_op[0] && (a_ext == min_val) && (b_ext == '1);
    res_neg   = (is_div && in_op[1]) ? a_neg : (a_neg ^ b_neg);
    last_step = word_eff ? CW'(32 / RADIX_BITS - 1) : CW'(XLEN / RADIX_BITS - 1);
  end

`ifdef MDU_FASTPATH_EN
  logic fast;
  assign fast = div0 || ovf || (!is_div && ((a_mag == '0) || (b_mag == '0)));
`endif

  // One radix step: shift-add multiply and restoring divide advance side by side.
  logic [PW-1:0]   prod_nx;
  logic [PW-1:0]   mcand_nx;
  logic [XLEN-1:0] mplier_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN:0]   rem_nx;

  always_comb begin
    prod_nx   = prod_q;
    mcand_nx  = mcand_q;
    mplier_nx = mplier_q;
    quo_nx    = quo_q;
    rem_nx    = rem_q;
    for (int i = 0; i < int'(RADIX_BITS); i++) begin
      if (mplier_nx[0]) prod_nx = prod_nx + mcand_nx;
      mcand_nx  = mcand_nx << 1;
      mplier_nx = mplier_nx >> 1;
      rem_nx    = {rem_nx[XLEN-1:0], quo_nx[XLEN-1]};
      quo_nx    = quo_nx << 1;
      if (rem_nx >= {1'b0, dvsr_q}) begin
        rem_nx    = rem_nx - {1'b0, dvsr_q};
        quo_nx[0] = 1'b1;
      end
    end
  end

  // Control FSM with registered handshake outputs; flush shares the reset path.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state     <= S_IDLE;
      in_ready  <= !reset;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      if (reset) out_result <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            op_q     <= in_op;
            word_q   <= word_eff;
            neg_q    <= res_neg;
            div0_q   <= div0;
            ovf_q    <= ovf;
            a_orig_q <= a_orig;
            prod_q   <= '0;
            mcand_q  <= PW'(a_mag);
            mplier_q <= b_mag;
            quo_q    <= word_eff ? (a_mag << WSHIFT) : a_mag;
            rem_q    <= '0;
            dvsr_q   <= b_mag;
            cnt_q    <= '0;
            last_q   <= last_step;
            state    <= S_RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef MDU_FASTPATH_EN
            if (fast) begin
              state      <= S_DONE;
              out_valid  <= 1'b1;
              out_result <= fix_result(in_op, word_eff, res_neg, div0, ovf,
                                       '0, '0, '0, a_orig);
            end
`endif
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_RUN: begin
          prod_q   <= prod_nx;
          mcand_q  <= mcand_nx;
          mplier_q <= mplier_nx;
          quo_q    <= quo_nx;
          rem_q    <= rem_nx;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == last_q) begin
            state      <= S_DONE;
            out_valid  <= 1'b1;
            out_result <= fix_result(op_q, word_q, neg_q, div0_q, ovf_q,
                                     prod_nx, quo_nx, rem_nx[XLEN-1:0], a_orig_q);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_mdu.sv
// tb_execute_mdu: scoreboard bench for execute_mdu (XLEN=64, RADIX_BITS=2); expectations come from
// test-plan constants and a native-arithmetic reference model.
module tb_execute_mdu;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned RADIX = 2;
`ifdef MDU_FASTPATH_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic            in_word;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            busy;

  execute_mdu #(.XLEN(XLEN), .RADIX_BITS(RADIX)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_word(in_word), .in_a(in_a), .in_b(in_b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] result;
    int unsigned lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mdu(input logic [2:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] pa, pb, ps;
    logic [127:0]        pu;
    logic signed [63:0]  sa, sbv, sq, sr;
    logic signed [31:0]  wa, wb, wq, wr;
    logic [31:0]         t;
    logic [63:0]         r;
    r = '0;
    t = '0;
    if (w) begin
      wa = a[31:0];
      wb = b[31:0];
      case (op)
        3'd0: t = a[31:0] * b[31:0];
        3'd4, 3'd6: begin
          if (wb == 0) t = (op == 3'd4) ? 32'hFFFF_FFFF : a[31:0];
          else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) t = (op == 3'd4) ? a[31:0] : 32'h0;
          else begin
            wq = wa / wb;
            wr = wa % wb;
            t  = (op == 3'd4) ? wq : wr;
          end
        end
        3'd5: t = (b[31:0] == 0) ? 32'hFFFF_FFFF : a[31:0] / b[31:0];
        3'd7: t = (b[31:0] == 0) ? a[31:0] : a[31:0] % b[31:0];
        default: t = '0;
      endcase
      r = {{32{t[31]}}, t};
    end else begin
      sa  = a;
      sbv = b;
      case (op)
        3'd0: r = a * b;
        3'd1: begin pa = sa; pb = sbv; ps = pa * pb; r = ps[127:64]; end
        3'd2: begin pa = sa; pb = {64'h0, b}; ps = pa * pb; r = ps[127:64]; end
        3'd3: begin pu = {64'h0, a} * {64'h0, b}; r = pu[127:64]; end
        3'd4, 3'd6: begin
          if (b == 0) r = (op == 3'd4) ? 64'hFFFF_FFFF_FFFF_FFFF : a;
          else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r = (op == 3'd4) ? a : 64'h0;
          else begin
            sq = sa / sbv;
            sr = sa % sbv;
            r  = (op == 3'd4) ? sq : sr;
          end
        end
        3'd5: r = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
        default: r = (b == 0) ? a : a % b;
      endcase
    end
    return r;
  endfunction

  task automatic issue(input string tag, input logic [2:0] op, input logic w,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                       input logic fast, input logic track);
    int unsigned n;
    exp_t        e;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_word  = w;
    in_a     = a;
    in_b     = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (track) begin
      e.tag    = tag;
      e.result = exp;
      e.lat    = (fast && FAST_EN) ? 1 : (w ? 32 : 64) / RADIX + 1;
      sb.push_back(e);
    end
  endtask

  task automatic wait_result(input int unsigned hold, input bit kill);
    exp_t        e;
    int unsigned k;
    logic [63:0] first;
    k = 1;
    while (!out_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (sb.size() == 0) begin
      check_eq("scoreboard_nonempty", 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    check_eq({e.tag, "_valid"}, 64'(out_valid), 64'd1);
    check_eq({e.tag, "_latency"}, 64'(k), 64'(e.lat));
    check_eq({e.tag, "_result"}, out_result, e.result);
    check_eq({e.tag, "_valid_in_ready"}, 64'(in_ready), 64'd0);
    first = out_result;
    for (int i = 0; i < int'(hold); i++) begin
      @(posedge clk); #1;
      check_eq({e.tag, "_hold_result"}, out_result, first);
      check_eq({e.tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check_eq({e.tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    if (kill) flush = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    flush     = 1'b0;
    out_ready = 1'b0;
    check_eq({e.tag, "_done_valid"}, 64'(out_valid), 64'd0);
    check_eq({e.tag, "_done_busy"}, 64'(busy), 64'd0);
    check_eq({e.tag, "_done_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int unsigned rises;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_word   = 1'b0;
    in_a      = '0;
    in_b      = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_result", out_result, 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

    issue("mul_7_m3", 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b1);
    wait_result(0, 1'b0);
    issue("mulhu_ones", 3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1);
    wait_result(5, 1'b0);
    issue("mulh_ones", 3'd1, 1'b0, '1, '1, 64'h0, 1'b0, 1'b1);
    wait_result(0, 1'b0);
    issue("mulhsu_neg", 3'd2, 1'b0, '1, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    wait_result(0, 1'b0);
    issue("div_ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1'b1, 1'b1);
    wait_result(0, 1'b0);
    issue("rem_ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h0, 1'b1, 1'b1);
    wait_result(0, 1'b0);
    issue("divu_by0", 3'd5, 1'b0, 64'd12345, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    wait_result(0, 1'b0);
    issue("remu_5_by0", 3'd7, 1'b0, 64'd5, 64'd0, 64'd5, 1'b1, 1'b1);
    wait_result(0, 1'b0);
    issue("div_9_by0", 3'd4, 1'b0, 64'd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    wait_result(2, 1'b0);
    issue("mul_zero", 3'd0, 1'b0, 64'd0, 64'd123, 64'd0, 1'b1, 1'b1);
    wait_result(0, 1'b0);
    issue("divw_m7_2", 3'd4, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b1);
    wait_result(0, 1'b0);
    issue("remw_m7_2", 3'd6, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    wait_result(0, 1'b0);
    issue("divuw_sext", 3'd5, 1'b1, 64'h1234_5678_8000_0000, 64'h9_0000_0001, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1);
    wait_result(0, 1'b0);
    issue("remuw_f", 3'd7, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'hF, 1'b0, 1'b1);
    wait_result(0, 1'b0);
    issue("mulw_wrap", 3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1);
    wait_result(0, 1'b0);

    // Flush in RUN: the killed divide must never present a result.
    issue("divu_flushed", 3'd5, 1'b0, 64'd100, 64'd7, 64'd0, 1'b0, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_run_busy", 64'(busy), 64'd0);
    check_eq("flush_run_in_ready", 64'(in_ready), 64'd1);
    rises = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) rises++;
    end
    check_eq("flush_run_no_valid", 64'(rises), 64'd0);
    issue("remu_after_flush", 3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 1'b0, 1'b1);
    wait_result(0, 1'b0);

    // in_valid coinciding with flush is ignored.
    in_valid = 1'b1;
    in_op    = 3'd0;
    in_word  = 1'b0;
    in_a     = 64'd3;
    in_b     = 64'd4;
    flush    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check_eq("flush_idle_busy", 64'(busy), 64'd0);
    check_eq("flush_idle_in_ready", 64'(in_ready), 64'd1);

    // Flush in DONE discards the result even with out_ready high.
    issue("div_killed_in_done", 3'd4, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0, 1'b1);
    wait_result(1, 1'b1);

    for (int i = 0; i < 16; i++) begin
      logic [2:0]  op;
      logic        w;
      logic [63:0] a;
      logic [63:0] b;
      op = 3'($urandom_range(0, 7));
      w  = ($urandom_range(0, 1) == 1) && ((op == 3'd0) || op[2]);
      a  = {$urandom, $urandom} | 64'd1;
      b  = {$urandom, $urandom} | 64'd1;
      if ((i % 4) == 1) b = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(1, 15));
      if ((i % 4) == 2) b = 64'($urandom_range(1, 999));
      if ((i % 4) == 3) a = {a[63:32], 32'h0000_0001 | {1'b1, 31'($urandom)}};
      issue($sformatf("rand%0d_op%0d_w%0d", i, op, w), op, w, a, b, ref_mdu(op, w, a, b), 1'b0, 1'b1);
      wait_result(0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
